// File: rtl/ps_serializer_fifo_if.sv
// Upstream-facing bundle of the serializer: parallel symbol handshake in,
// serial line and status out.
interface ps_serializer_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             data_out;
  logic             sym_start;
  logic             idle_out;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] idle_count;

  modport master (
    output in_data, in_valid,
    input  in_ready, data_out, sym_start, idle_out, fifo_level, idle_count
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, data_out, sym_start, idle_out, fifo_level, idle_count
  );
endinterface

// File: rtl/ps_serializer_fifo.sv
// Parallel-to-serial converter with a small symbol FIFO; sends IDLE_SYM
// whenever the FIFO is empty at a word boundary. Single serial clock domain.
module ps_serializer_fifo #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_SYM  = 8'hBC,
  parameter bit               MSB_FIRST = 1'b1,
  parameter int unsigned      CNT_W     = 16
) (
  input logic                 clk_32f,
  input logic                 reset_L,
  ps_serializer_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] idle_cnt;
  logic             data_out_r;
  logic             sym_start_r;
  logic             idle_r;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             load;

  always_comb begin
    full  = (level == LW'(DEPTH));
    empty = (level == '0);
    load  = (bit_cnt == CW'(WIDTH - 1));
    // Ready depends only on the pre-edge level, so a full FIFO ignores
    // input even on an edge where it also pops.
    push  = bus.in_valid && !full;
    pop   = load && !empty;
    word  = pop ? mem[rd_ptr] : IDLE_SYM;
  end

  always_ff @(posedge clk_32f) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt     <= CW'(WIDTH - 1);
      sreg        <= '0;
      data_out_r  <= 1'b0;
      sym_start_r <= 1'b0;
      idle_r      <= 1'b0;
      idle_cnt    <= '0;
    end else if (load) begin
      bit_cnt     <= '0;
      sym_start_r <= 1'b1;
      idle_r      <= !pop;
      data_out_r  <= MSB_FIRST ? word[WIDTH-1] : word[0];
      sreg        <= MSB_FIRST ? (word << 1) : (word >> 1);
      if (!pop && (idle_cnt != '1)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      bit_cnt     <= bit_cnt + 1'b1;
      sym_start_r <= 1'b0;
      data_out_r  <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      sreg        <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    end
  end

  assign bus.in_ready   = !full;
  assign bus.data_out   = data_out_r;
  assign bus.sym_start  = sym_start_r;
  assign bus.idle_out   = idle_r;
  assign bus.fifo_level = level;
  assign bus.idle_count = idle_cnt;
endmodule

// File: tb/tb_ps_serializer_fifo.sv
// Randomized bench for ps_serializer_fifo: an MSB-first and an LSB-first
// (narrow idle counter) instance share stimulus and a queue-based model.
module tb_ps_serializer_fifo;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam logic [7:0]  IDLE = 8'hBC;

  logic clk_32f;
  logic reset_L;

  ps_serializer_fifo_if #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) bus0 ();
  ps_serializer_fifo_if #(.WIDTH(W), .DEPTH(D), .CNT_W(3))  bus1 ();

  ps_serializer_fifo #(
    .WIDTH(W), .DEPTH(D), .IDLE_SYM(IDLE), .MSB_FIRST(1'b1), .CNT_W(16)
  ) dut0 (
    .clk_32f(clk_32f), .reset_L(reset_L), .bus(bus0.slave)
  );

  ps_serializer_fifo #(
    .WIDTH(W), .DEPTH(D), .IDLE_SYM(IDLE), .MSB_FIRST(1'b0), .CNT_W(3)
  ) dut1 (
    .clk_32f(clk_32f), .reset_L(reset_L), .bus(bus1.slave)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of pending words plus the word on the line
  // and the position within it.
  logic [7:0]  q[$];
  int unsigned pos;
  logic [7:0]  cur_word;
  bit          cur_idle;
  bit          started;
  int unsigned icnt0;
  int unsigned icnt1;

  task automatic model_reset();
    q.delete();
    pos      = W - 1;
    cur_word = '0;
    cur_idle = 1'b0;
    started  = 1'b0;
    icnt0    = 0;
    icnt1    = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d);
    bit acc;
    acc = v && (q.size() < D);
    if (pos == W - 1) begin
      started = 1'b1;
      pos     = 0;
      if (q.size() > 0) begin
        cur_word = q.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur_word = IDLE;
        cur_idle = 1'b1;
        if (icnt0 < 65535) icnt0++;
        if (icnt1 < 7) icnt1++;
      end
    end else begin
      pos++;
    end
    if (acc) q.push_back(d);
  endtask

  function automatic logic exp_bit(input bit msb);
    if (!started) return 1'b0;
    return msb ? cur_word[W-1-pos] : cur_word[pos];
  endfunction

  task automatic compare_all();
    logic ss;
    ss = started && (pos == 0);
    chk("d0_data",  bus0.data_out,   exp_bit(1'b1));
    chk("d0_start", bus0.sym_start,  ss);
    chk("d0_idle",  bus0.idle_out,   cur_idle);
    chk("d0_level", bus0.fifo_level, q.size());
    chk("d0_ready", bus0.in_ready,   q.size() < D);
    chk("d0_icnt",  bus0.idle_count, icnt0);
    chk("d1_data",  bus1.data_out,   exp_bit(1'b0));
    chk("d1_start", bus1.sym_start,  ss);
    chk("d1_idle",  bus1.idle_out,   cur_idle);
    chk("d1_level", bus1.fifo_level, q.size());
    chk("d1_icnt",  bus1.idle_count, icnt1);
  endtask

  task automatic drive(input bit v, input logic [7:0] d);
    bus0.in_valid = v;
    bus1.in_valid = v;
    bus0.in_data  = d;
    bus1.in_data  = d;
  endtask

  // Called at a falling edge: check, drive, advance model across one edge.
  task automatic cycle(input bit v, input logic [7:0] d);
    compare_all();
    drive(v, d);
    model_edge(v, d);
    @(negedge clk_32f);
  endtask

  task automatic random_phase(input int unsigned n, input int unsigned pct);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom_range(99) < pct), 8'($urandom));
    end
  endtask

  task automatic mid_reset();
    drive(1'b0, 8'h00);
    model_edge(1'b0, 8'h00);
    @(posedge clk_32f);
    #2 reset_L = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk_32f);
    compare_all();
    reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] nxt;
    reset_L = 1'b0;
    drive(1'b0, 8'h00);
    model_reset();
    repeat (2) @(negedge clk_32f);
    compare_all();
    reset_L = 1'b1;

    // Idle only: three COM symbols after 24 edges.
    for (int i = 0; i < 24; i++) cycle(1'b0, 8'h00);
    chk("idle3", bus0.idle_count, 32'd3);

    random_phase(300, 30);

    // Continuous valid with an ascending sequence advancing only on accept.
    nxt = 8'h10;
    for (int i = 0; i < 80; i++) begin
      if (nxt <= 8'h17) begin
        bit acc;
        acc = (q.size() < D);
        cycle(1'b1, nxt);
        if (acc) nxt++;
      end else begin
        cycle(1'b0, 8'h00);
      end
    end
    chk("seq_done", nxt, 32'h18);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00);

    random_phase(300, 70);

    for (int r = 0; r < 4; r++) begin
      random_phase($urandom_range(30, 5), 80);
      mid_reset();
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
      chk("rst_icnt", bus0.idle_count, 32'd2);
    end

    random_phase(200, 50);
    // Enough idle symbols to saturate the narrow counter.
    for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);
    chk("sat_icnt", bus1.idle_count, 32'd7);
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps_serializer_fifo.md
Name: ps_serializer_fifo

Overview:
Parametrised parallel-to-serial converter for the PHY TX path. It buffers parallel symbols in a small FIFO and emits them one bit per clock on a single serial line. When no symbol is pending it substitutes a programmable idle symbol (COM, 8'hBC by default). It runs entirely in the serial-bit clock domain and reports word alignment, idle insertion and backpressure to the upstream byte-striping logic.

Parameters:
WIDTH, 8, symbol width in bits (>=2); one word is WIDTH serial clocks.
DEPTH, 4, FIFO entries (power of 2, >=2).
IDLE_SYM, 8'hBC, symbol sent when the FIFO is empty at a word boundary (WIDTH bits).
MSB_FIRST, 1, 1: bit WIDTH-1 goes out first; 0: bit 0 goes out first.
CNT_W, 16, width of the idle-insertion counter.

Ports:
clk_32f  in  1  serial bit clock; all logic on rising edge.
reset_L  in  1  asynchronous, active-low reset.
in_data  in  WIDTH  parallel symbol from upstream.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  FIFO can accept a word; transfer when in_valid && in_ready.
data_out  out  1  serial bit stream, registered.
sym_start  out  1  high in the cycle where data_out carries the first bit of a symbol.
idle_out  out  1  high for all WIDTH cycles of an inserted IDLE_SYM.
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
idle_count  out  CNT_W  number of inserted idle symbols; saturates at all-ones.

Behaviour:
- Reset (reset_L=0, async): data_out=0, sym_start=0, idle_out=0, fifo_level=0, idle_count=0, FIFO pointers=0, shift register=0, bit counter=WIDTH-1. in_ready=1 once reset is released, because it is combinational on !full.
- Bit counter: counts 0..WIDTH-1 and wraps. A load edge is an edge where the counter equals WIDTH-1, so the first rising edge after reset release is a load edge.
- On a load edge:
  - If the FIFO is not empty, pop the head word W. Otherwise W=IDLE_SYM, idle_count increments (saturating) and idle_out<=1. If a word was popped, idle_out<=0.
  - data_out<=first bit of W. The shift register takes the remaining WIDTH-1 bits in send order. sym_start<=1. The counter goes to 0.
- On other edges: data_out<=next bit from the shift register, sym_start<=0, idle_out holds, counter increments.
- Latency: a word written into an empty FIFO at edge k appears on data_out from the next load edge after k. It is never popped on the same edge it is written; the FIFO has no fall-through.
- Word boundaries are fixed; they are never realigned by input timing.
- FIFO:
  - Push when in_valid && in_ready. in_ready = (fifo_level != DEPTH).
  - A push and a pop on the same edge are both performed; level is unchanged.
  - When full, in_ready=0 and in_data is ignored, even if a pop happens that edge. Ready only rises in the following cycle.
  - Pointers wrap modulo DEPTH.
  - A pop on an empty FIFO never occurs; idle substitution applies instead.
- Ordering: words leave in strict FIFO order. Bit order is fixed by MSB_FIRST.
- idle_count: stays at all-ones once saturated.
- Reset mid-symbol: the partial symbol is abandoned, FIFO contents are discarded, and the next transmission starts with a fresh load on the first edge after release.
- in_valid may toggle freely. in_data only needs to be stable in cycles where in_valid && in_ready.

Test Plan:
1. No input after reset (WIDTH=8, MSB_FIRST=1) -> data_out repeats 1,0,1,1,1,1,0,0 (8'hBC); sym_start pulses every 8 cycles; idle_out=1; idle_count=3 after 3 symbols.
2. Push 8'hA5 while the FIFO is empty, mid-symbol -> the current idle symbol completes, then 1,0,1,0,0,1,0,1 follows with sym_start=1 and idle_out=0 on its first bit; fifo_level returns to 0.
3. MSB_FIRST=0, push 8'h01 -> data_out sequence is 1,0,0,0,0,0,0,0.
4. Hold in_valid=1 with words 8'h10..8'h17 -> in_ready drops when fifo_level=4; words go out in order 10,11,...,17; no idle symbol between them once the first is loaded; none lost.
5. Push on the same edge as a pop with fifo_level=2 -> level stays 2; order is preserved.
6. Assert reset_L=0 on bit 3 of 8'hA5 with 2 words queued -> outputs clear asynchronously; after release the first symbol out is 8'hBC; idle_count=1.
